// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_pkg : widths, constants and helpers shared by the register file   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package regfile_pkg;

  localparam int c_reg_width  = 32;
  localparam int c_addr_width = 5;
  localparam int c_reg_num    = 32;

  typedef logic [c_reg_width-1:0]  reg_bus_t;
  typedef logic [c_addr_width-1:0] reg_addr_t;

  localparam reg_bus_t  c_zero_word     = '0;
  localparam reg_addr_t c_zero_reg      = '0;
  localparam logic      c_write_enable  = 1'b1;
  localparam logic      c_write_disable = 1'b0;
  localparam logic      c_read_enable   = 1'b1;
  localparam logic      c_read_disable  = 1'b0;

  function automatic logic is_zero_reg(input reg_addr_t addr);
    return addr == c_zero_reg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_rd_port : read-port gating (enable, x0) and optional write bypass  |
// | Optional feature: REGFILE_BYPASS_EN adds the same-cycle write-through mux  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module regfile_rd_port
  import regfile_pkg::*;
(
  input  logic      i_re,
  input  reg_addr_t i_raddr,
  input  reg_bus_t  i_reg_data,
`ifdef REGFILE_BYPASS_EN
  input  logic      i_byp_we,
  input  reg_addr_t i_byp_addr,
  input  reg_bus_t  i_byp_data,
`endif
  output reg_bus_t  o_rdata
);

  always_comb begin
    o_rdata = c_zero_word;
    if (i_re == c_read_enable && !is_zero_reg(i_raddr)) begin
      o_rdata = i_reg_data;
`ifdef REGFILE_BYPASS_EN
      // Write-back data in flight to this address wins over the stored copy
      if (i_byp_we && i_byp_addr == i_raddr) begin
        o_rdata = i_byp_data;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile : 32 x 32-bit register file, 2 read ports, write-back + debug port |
// | Optional feature: REGFILE_BYPASS_EN enables write-through read bypass      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module regfile
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      we_i,
  input  reg_addr_t waddr_i,
  input  reg_bus_t  wdata_i,
  input  logic      re1_i,
  input  reg_addr_t raddr1_i,
  output reg_bus_t  rdata1_o,
  input  logic      re2_i,
  input  reg_addr_t raddr2_i,
  output reg_bus_t  rdata2_o,
  input  logic      dbg_we_i,
  input  reg_addr_t dbg_addr_i,
  input  reg_bus_t  dbg_wdata_i,
  output reg_bus_t  dbg_rdata_o
);

  reg_bus_t r_regs [c_reg_num];

  logic w_wb_we;
  logic w_dbg_we;

  assign w_wb_we  = (we_i == c_write_enable) && !is_zero_reg(waddr_i);
  // Debug write is dropped when write-back targets the same register
  assign w_dbg_we = (dbg_we_i == c_write_enable) && !is_zero_reg(dbg_addr_i) &&
                    !((we_i == c_write_enable) && (waddr_i == dbg_addr_i));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_reg_num; i++) begin
        r_regs[i] <= c_zero_word;
      end
    end else begin
      if (w_dbg_we) begin
        r_regs[dbg_addr_i] <= dbg_wdata_i;
      end
      if (w_wb_we) begin
        r_regs[waddr_i] <= wdata_i;
      end
    end
  end

  assign dbg_rdata_o = is_zero_reg(dbg_addr_i) ? c_zero_word : r_regs[dbg_addr_i];

`ifdef REGFILE_BYPASS_EN
  logic w_byp_we;
  // Writes are ignored during reset, so the bypass must not leak them either
  assign w_byp_we = w_wb_we && !rst;
`endif

  regfile_rd_port u_rd_port1 (
    .i_re       (re1_i),
    .i_raddr    (raddr1_i),
    .i_reg_data (r_regs[raddr1_i]),
`ifdef REGFILE_BYPASS_EN
    .i_byp_we   (w_byp_we),
    .i_byp_addr (waddr_i),
    .i_byp_data (wdata_i),
`endif
    .o_rdata    (rdata1_o)
  );

  regfile_rd_port u_rd_port2 (
    .i_re       (re2_i),
    .i_raddr    (raddr2_i),
    .i_reg_data (r_regs[raddr2_i]),
`ifdef REGFILE_BYPASS_EN
    .i_byp_we   (w_byp_we),
    .i_byp_addr (waddr_i),
    .i_byp_data (wdata_i),
`endif
    .o_rdata    (rdata2_o)
  );

endmodule
`default_nettype wire
